// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 register IDs, widths and the writeback entry type.
package y86_pkg;
  localparam int REG_W = 4;
  localparam int DATA_W = 64;
  localparam logic [REG_W-1:0] RRAX = 4'h0, RRCX = 4'h1, RRDX = 4'h2, RRBX = 4'h3;
  localparam logic [REG_W-1:0] RRSP = 4'h4, RRBP = 4'h5, RRSI = 4'h6, RRDI = 4'h7;
  localparam logic [REG_W-1:0] R8 = 4'h8, R9 = 4'h9, R10 = 4'hA, R11 = 4'hB;
  localparam logic [REG_W-1:0] R12 = 4'hC, R13 = 4'hD, R14 = 4'hE, RNONE = 4'hF;
  typedef struct packed {
    logic [REG_W-1:0] regId;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: in-order circular buffer with two pushes, one pop and in-place data updates.
module rf_wb_fifo import y86_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push0,
  input  wb_entry_t         ent0,
  input  logic              push1,
  input  wb_entry_t         ent1,
  input  logic              pop,
  input  logic [DEPTH-1:0]  updEn,
  input  logic [DATA_W-1:0] updData [DEPTH],
  output wb_entry_t         entries [DEPTH],
  output logic [PW-1:0]     headPtr,
  output logic [CW-1:0]     count
);
  logic [PW-1:0] tailPtr, slot1;
  assign slot1 = tailPtr + PW'(push0);
  always_ff @(posedge clock)
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count <= '0;
    end else begin
      headPtr <= headPtr + PW'(pop);
      tailPtr <= tailPtr + PW'(push0) + PW'(push1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  // Storage needs no reset: count alone decides which slots are visible.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++)
      if (updEn[i]) entries[i].data <= updData[i];
    if (push0) entries[tailPtr] <= ent0;
    if (push1) entries[slot1] <= ent1;
  end
endmodule

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges E/M writebacks onto one register-file port with forwarding.
// Optional RF_WB_COALESCE_EN folds writes to an already-queued non-head register in place.
module rf_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   e_valid,
  input  logic [3:0]             e_reg,
  input  logic [63:0]            e_data,
  input  logic                   m_valid,
  input  logic [3:0]             m_reg,
  input  logic [63:0]            m_data,
  output logic                   in_ready,
  output logic                   rf_we,
  output logic [3:0]             rf_waddr,
  output logic [63:0]            rf_wdata,
  input  logic [3:0]             q_reg_a,
  output logic                   q_hit_a,
  output logic [63:0]            q_data_a,
  input  logic [3:0]             q_reg_b,
  output logic                   q_hit_b,
  output logic [63:0]            q_data_b,
  output logic [$clog2(DEPTH):0] pending
);
  import y86_pkg::*;
  localparam int PW = $clog2(DEPTH);
  wb_entry_t entries [DEPTH];
  wb_entry_t head, ent0, ent1;
  logic [PW-1:0] headPtr;
  logic eAcc, mAcc, push0, push1;
  logic [DEPTH-1:0] updEn;
  logic [DATA_W-1:0] updData [DEPTH];
  assign in_ready = pending <= (PW+1)'(DEPTH - 2);
  assign eAcc = e_valid && in_ready && e_reg != RNONE;
  assign mAcc = m_valid && in_ready && m_reg != RNONE;
  assign ent0 = {e_reg, e_data};
  assign ent1 = {m_reg, m_data};
  assign rf_we = pending != '0;
  assign head = entries[headPtr];
  assign rf_waddr = rf_we ? head.regId : '0;
  assign rf_wdata = rf_we ? head.data : '0;
  // Walk oldest to youngest so the last match is the newest value.
  always_comb begin
    q_hit_a = 1'b0;
    q_data_a = '0;
    q_hit_b = 1'b0;
    q_data_b = '0;
    for (int k = 0; k < DEPTH; k++)
      if (k < int'(pending)) begin
        if (q_reg_a != RNONE && entries[headPtr + PW'(k)].regId == q_reg_a) begin
          q_hit_a = 1'b1;
          q_data_a = entries[headPtr + PW'(k)].data;
        end
        if (q_reg_b != RNONE && entries[headPtr + PW'(k)].regId == q_reg_b) begin
          q_hit_b = 1'b1;
          q_data_b = entries[headPtr + PW'(k)].data;
        end
      end
  end
`ifdef RF_WB_COALESCE_EN
  logic eHit, mHit, sameReg;
  logic [PW-1:0] eIdx, mIdx;
  // The head is excluded: it leaves the queue on this same edge.
  always_comb begin
    eHit = 1'b0;
    mHit = 1'b0;
    eIdx = '0;
    mIdx = '0;
    for (int k = 1; k < DEPTH; k++)
      if (k < int'(pending)) begin
        if (entries[headPtr + PW'(k)].regId == e_reg) begin
          eHit = 1'b1;
          eIdx = headPtr + PW'(k);
        end
        if (entries[headPtr + PW'(k)].regId == m_reg) begin
          mHit = 1'b1;
          mIdx = headPtr + PW'(k);
        end
      end
  end
  assign sameReg = eAcc && mAcc && e_reg == m_reg;
  assign push0 = eAcc && !sameReg && !eHit;
  assign push1 = mAcc && !mHit;
  always_comb begin
    updEn = '0;
    for (int i = 0; i < DEPTH; i++) begin
      updEn[i] = (eAcc && !sameReg && eHit && eIdx == PW'(i)) || (mAcc && mHit && mIdx == PW'(i));
      updData[i] = (mAcc && mHit && mIdx == PW'(i)) ? m_data : e_data;
    end
  end
`else
  assign push0 = eAcc;
  assign push1 = mAcc;
  assign updEn = '0;
  always_comb
    for (int i = 0; i < DEPTH; i++) updData[i] = '0;
`endif
  rf_wb_fifo #(.DEPTH(DEPTH)) fifo (
    .clock(clock),
    .reset(reset),
    .push0(push0),
    .ent0(ent0),
    .push1(push1),
    .ent1(ent1),
    .pop(rf_we),
    .updEn(updEn),
    .updData(updData),
    .entries(entries),
    .headPtr(headPtr),
    .count(pending)
  );
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed stimulus against a queue-based scoreboard of expected writes.
module tb_rf_writeback_arbiter;
  localparam int DEPTH = 4;
  typedef struct {
    logic [3:0] r;
    logic [63:0] d;
  } ent_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic e_valid = 1'b0, m_valid = 1'b0;
  logic [3:0] e_reg = 4'h0, m_reg = 4'h0, q_reg_a = 4'hF, q_reg_b = 4'hF;
  logic [63:0] e_data = '0, m_data = '0;
  logic in_ready, rf_we, q_hit_a, q_hit_b;
  logic [3:0] rf_waddr;
  logic [63:0] rf_wdata, q_data_a, q_data_b;
  logic [2:0] pending;
  ent_t sb[$];
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  rf_writeback_arbiter #(.DEPTH(DEPTH), .RNONE(4'hF)) dut (
    .clock(clock), .reset(reset),
    .e_valid(e_valid), .e_reg(e_reg), .e_data(e_data),
    .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data),
    .in_ready(in_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_reg_a(q_reg_a), .q_hit_a(q_hit_a), .q_data_a(q_data_a),
    .q_reg_b(q_reg_b), .q_hit_b(q_hit_b), .q_data_b(q_data_b),
    .pending(pending)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input logic [3:0] r, input logic [63:0] d);
`ifdef RF_WB_COALESCE_EN
    foreach (sb[i])
      if (sb[i].r == r) begin
        sb[i].d = d;
        return;
      end
`endif
    sb.push_back('{r, d});
  endtask

  task automatic fwd(input logic [3:0] r, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d = '0;
    foreach (sb[i])
      if (r != 4'hF && sb[i].r == r) begin
        hit = 1'b1;
        d = sb[i].d;
      end
  endtask

  // One cycle: drive, check registered-state outputs against the model, then advance the model.
  task automatic step(input logic ev, input logic [3:0] er, input logic [63:0] ed,
                      input logic mv, input logic [3:0] mr, input logic [63:0] md,
                      input logic [3:0] qa, input logic [3:0] qb, output bit acc);
    logic rdy, ha, hb;
    logic [63:0] da, db;
    @(negedge clock);
    e_valid = ev; e_reg = er; e_data = ed;
    m_valid = mv; m_reg = mr; m_data = md;
    q_reg_a = qa; q_reg_b = qb;
    #1;
    rdy = (DEPTH - sb.size()) >= 2;
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("pending", 64'(pending), 64'(sb.size()));
    chk("rf_we", 64'(rf_we), 64'(sb.size() != 0));
    chk("rf_waddr", 64'(rf_waddr), sb.size() != 0 ? 64'(sb[0].r) : 64'h0);
    chk("rf_wdata", rf_wdata, sb.size() != 0 ? sb[0].d : 64'h0);
    fwd(qa, ha, da);
    fwd(qb, hb, db);
    chk("q_hit_a", 64'(q_hit_a), 64'(ha));
    chk("q_data_a", q_data_a, da);
    chk("q_hit_b", 64'(q_hit_b), 64'(hb));
    chk("q_data_b", q_data_b, db);
    if (sb.size() != 0) void'(sb.pop_front());
    if (ev && rdy && er != 4'hF) enq(er, ed);
    if (mv && rdy && mr != 4'hF) enq(mr, md);
    acc = rdy;
    @(posedge clock);
  endtask

  task automatic idle(input logic [3:0] qa, input logic [3:0] qb);
    bit a;
    step(1'b0, 4'h0, '0, 1'b0, 4'h0, '0, qa, qb, a);
  endtask

  // Producer holds a request until the model says it was taken, with a bounded retry budget.
  task automatic send(input logic ev, input logic [3:0] er, input logic [63:0] ed,
                      input logic mv, input logic [3:0] mr, input logic [63:0] md);
    bit a;
    int tries = 0;
    do begin
      step(ev, er, ed, mv, mr, md, mr, er, a);
      tries++;
    end while (!a && tries < 8);
    total++;
    assert (a) else begin
      bad++;
      $error("FAIL send_timeout observed=%0d expected=1", a);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    e_valid = 1'b0;
    m_valid = 1'b0;
    @(posedge clock);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    bit a;
    do_reset();
    idle(4'h0, 4'hF);
    // single E write
    send(1'b1, 4'h0, 64'h11, 1'b0, 4'h0, '0);
    idle(4'h0, 4'h0);
    idle(4'h0, 4'h0);
    // E and M to %rsp in the same cycle: M is younger and wins forwarding
    send(1'b1, 4'h4, 64'h100, 1'b1, 4'h4, 64'h200);
    idle(4'h4, 4'hF);
    idle(4'h4, 4'h0);
    idle(4'h4, 4'h4);
    // three back-to-back dual writes; the third must be held while full
    send(1'b1, 4'h1, 64'hA1, 1'b1, 4'h2, 64'hA2);
    send(1'b1, 4'h3, 64'hA3, 1'b1, 4'h5, 64'hA5);
    send(1'b1, 4'h6, 64'hA6, 1'b1, 4'h7, 64'hA7);
    for (int i = 0; i < 6; i++) idle(4'h6, 4'h1);
    // RNONE on both streams is dropped
    step(1'b1, 4'hF, 64'hDEAD, 1'b1, 4'hF, 64'hBEEF, 4'hF, 4'hF, a);
    idle(4'hF, 4'h0);
    // RNONE dropped while the queue is not ready
    send(1'b1, 4'h8, 64'h8, 1'b1, 4'h9, 64'h9);
    send(1'b1, 4'hA, 64'hA, 1'b1, 4'hB, 64'hB);
    step(1'b1, 4'hF, 64'h1, 1'b1, 4'hF, 64'h2, 4'hA, 4'hB, a);
    for (int i = 0; i < 3; i++) idle(4'h8, 4'hB);
    // reset with three entries queued discards them
    send(1'b1, 4'h8, 64'h81, 1'b1, 4'h9, 64'h91);
    send(1'b1, 4'hA, 64'hA1, 1'b1, 4'hB, 64'hB1);
    do_reset();
    idle(4'h9, 4'hA);
    idle(4'hB, 4'h8);
    // repeated writes to %rbx behind another entry
    send(1'b1, 4'h0, 64'h5, 1'b1, 4'h1, 64'h6);
    send(1'b1, 4'h3, 64'h1, 1'b0, 4'h0, '0);
    send(1'b1, 4'h3, 64'h2, 1'b0, 4'h0, '0);
    for (int i = 0; i < 3; i++) idle(4'h3, 4'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
